// File: rtl/serial_nibble_adder_if.sv
// Start/busy/done handshake and operand/result bus
// for the serial nibble adder.
interface serial_nibble_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/serial_nibble_adder.sv
// Wide adder reusing one 4-bit ripple slice per
// clock, LSB nibble first; result held until next done.
module serial_nibble_adder #(
  parameter  int WIDTH   = 32,
  localparam int NIBBLES = WIDTH / 4,
  localparam int IW      = $clog2(NIBBLES)
) (
  input logic                 clk,
  input logic                 rst,
  serial_nibble_adder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             step;
  logic             finish;
  logic             last;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             done_q;
  logic [IW-1:0]    idx;
  logic [4:0]       nib;

  assign nib = {1'b0, op_a[3:0]}
             + {1'b0, op_b[3:0]}
             + {4'd0, carry};

  assign acc_nxt = {nib[3:0], acc[WIDTH-1:4]};
  assign last    = (idx == IW'(NIBBLES - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: accept in IDLE, leave ADD after last nibble.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = ADD;
      ADD:  if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): load = bus.start;
      (state_q == ADD): begin
        step   = 1'b1;
        finish = last;
      end
      default: ;
    endcase
  end

  // Operand shifters, accumulator and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        op_a  <= bus.A;
        op_b  <= bus.B;
        carry <= bus.Cin;
        idx   <= '0;
        acc   <= '0;
      end else if (step) begin
        op_a  <= op_a >> 4;
        op_b  <= op_b >> 4;
        carry <= nib[4];
        idx   <= idx + IW'(1);
        acc   <= acc_nxt;
        if (finish) begin
          sum_q  <= acc_nxt;
          cout_q <= nib[4];
        end
      end
    end
  end

  assign bus.busy = (state_q == ADD);
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench: stimulus pushes expected
// {Cout,Sum}, a monitor pops on every done pulse.
module tb_serial_nibble_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] last_exp = '0;

  serial_nibble_adder_if #(.WIDTH(32)) bus ();

  serial_nibble_adder #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // Monitor: pop on done, else result must hold.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got %h_%h, no result pending",
                   bus.Cout, bus.Sum);
        end else begin
          last_exp = exp_q.pop_front();
          if ({bus.Cout, bus.Sum} !== last_exp) begin
            errors++;
            $display("FAIL result: got %h_%h, want %h",
                     bus.Cout, bus.Sum, last_exp);
          end
        end
      end else if ({bus.Cout, bus.Sum} !== last_exp) begin
        errors++;
        $display("FAIL hold: got %h_%h, want %h",
                 bus.Cout, bus.Sum, last_exp);
      end
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle;
  // returns #1 after the done edge.
  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        cin,
                        input bit          poke);
    chk("idle_before_start", 64'(bus.busy), 64'(0));
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.Cin   = 1'($urandom);
    for (int k = 1; k <= 8; k++) begin
      if (poke && k == 2) begin
        bus.start = 1'b1;
        bus.A     = 32'd5;
        bus.B     = 32'd5;
      end
      if (poke && k == 3) bus.start = 1'b0;
      @(posedge clk); #1;
      chk("busy", 64'(bus.busy), 64'(k < 8));
      chk("done", 64'(bus.done), 64'(k == 8));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_sum",  64'(bus.Sum),  64'(0));
    chk("rst_cout", 64'(bus.Cout), 64'(0));
    rst = 1'b0;
    idle(2);

    run_op(32'h0000_000F, 32'h0000_0001, 1'b0, 0);
    idle(1);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    idle(2);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0);
    idle(1);

    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    idle(1);

    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 0);
      idle($urandom_range(0, 2));
    end

    // Abort an operation after its fourth edge.
    bus.start = 1'b1;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0123_4567;
    bus.Cin   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle(3);
    rst = 1'b1;
    exp_q.delete();
    last_exp = '0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_sum",  64'(bus.Sum),  64'(0));
    chk("abort_cout", 64'(bus.Cout), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", 64'(bus.done), 64'(0));
    end

    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
